// File: rtl/core_pkg.sv
// Shared definitions for the hazard scoreboard: controller states,
// register-class encoding, the hard-wired zero register, and a
// saturating increment used by the optional stall counters.
package core_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } sb_state_e;

  localparam logic [4:0] REG_X0  = 5'd0;
  localparam logic       CLS_INT = 1'b0;
  localparam logic       CLS_FP  = 1'b1;

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/sb_regs.sv
// Pending-write bit array for the multi-cycle unit's destination.
// Holds NREG bits per register class (two classes when FLOAT != 0).
// The clear port is bypassed onto the read ports so a register freed by
// a grant reads as not-pending in that same cycle. Int x0 is never pending.
module sb_regs
  import core_pkg::*;
#(
  parameter int FLOAT = 0,
  parameter int NREG  = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_en,
  input  logic       set_cls,
  input  logic [4:0] set_idx,
  input  logic       clr_en,
  input  logic       clr_cls,
  input  logic [4:0] clr_idx,
  input  logic       rs1_cls,
  input  logic [4:0] rs1_idx,
  input  logic       rs2_cls,
  input  logic [4:0] rs2_idx,
  input  logic       rd_cls,
  input  logic [4:0] rd_idx,
  output logic       p_rs1,
  output logic       p_rs2,
  output logic       p_rd
);

  localparam int NCLS = (FLOAT != 0) ? 2 : 1;
  localparam int NBIT = NCLS * NREG;

  logic [NBIT-1:0] pend;
  logic [NBIT-1:0] vis;

  // True when (cls, idx) names flat entry k; class collapses to INT without FLOAT.
  function automatic logic hit(input logic cls, input logic [4:0] idx, input int k);
    logic eff_cls;
    logic k_cls;
    eff_cls = (FLOAT != 0) ? cls : CLS_INT;
    k_cls   = (k >= NREG) ? CLS_FP : CLS_INT;
    return (eff_cls == k_cls) && (idx == 5'(k % NREG));
  endfunction

  // Pending bits: set on issue, cleared on grant; entry 0 (int x0) stays clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
    end else begin
      for (int k = 0; k < NBIT; k++) begin
        if (set_en && (k != 0) && hit(set_cls, set_idx, k)) begin
          pend[k] <= 1'b1;
        end else if (clr_en && hit(clr_cls, clr_idx, k)) begin
          pend[k] <= 1'b0;
        end
      end
    end
  end

  // View seen by ID: a same-cycle clear already counts as released.
  always_comb begin
    vis = '0;
    for (int k = 0; k < NBIT; k++) begin
      vis[k] = pend[k] & ~(clr_en & hit(clr_cls, clr_idx, k));
    end
  end

  // Three read ports over the bypassed view.
  always_comb begin
    p_rs1 = 1'b0;
    p_rs2 = 1'b0;
    p_rd  = 1'b0;
    for (int k = 0; k < NBIT; k++) begin
      p_rs1 = p_rs1 | (vis[k] & hit(rs1_cls, rs1_idx, k));
      p_rs2 = p_rs2 | (vis[k] & hit(rs2_cls, rs2_idx, k));
      p_rd  = p_rd  | (vis[k] & hit(rd_cls, rd_idx, k));
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard controller between ID and EX/WB: load-use detection, a scoreboard
// for one outstanding multi-cycle op, its issue/complete handshake and the
// arbitration of the shared register-file write port.
// Optional macro SB_PERF_CNT_EN adds saturating stall-cause counters.
module hazard_scoreboard
  import core_pkg::*;
#(
  parameter int FLOAT = 0,
  parameter int NREG  = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] rs1_id,
  input  logic [4:0] rs2_id,
  input  logic [1:0] float_read,
  input  logic [4:0] rd_id,
  input  logic       fw_id,
  input  logic       wb_id,
  input  logic       mc_id,
  input  logic       br_flush,
  input  logic       ld_ie,
  input  logic       wb_ie,
  input  logic       fw_ie,
  input  logic [4:0] rd_ie,
  output logic       mc_req,
  input  logic       mc_ack,
  input  logic       mc_done,
  input  logic [4:0] mc_rd,
  input  logic       mc_fw,
  input  logic       pipe_wb_valid,
  output logic       wb_sel,
  output logic       mc_grant,
  output logic       stall_id,
  output logic       bubble_ex,
  output logic       hold_wb
`ifdef SB_PERF_CNT_EN
  ,
  output logic [31:0] cnt_lu,
  output logic [31:0] cnt_raw,
  output logic [31:0] cnt_struct
`endif
);

  localparam logic HAS_FP = (FLOAT != 0);

  sb_state_e state, state_nxt;

  logic rs1_cls, rs2_cls, rd_cls, ex_cls, done_cls;
  logic p_rs1, p_rs2, p_rd;
  logic lu_hit, raw_hit, waw_hit, struct_hit;
  logic grant_busy, unit_free, in_drain, req_raw, issue, set_en, clr_en;

  assign rs1_cls  = HAS_FP & float_read[1];
  assign rs2_cls  = HAS_FP & float_read[0];
  assign rd_cls   = HAS_FP & fw_id;
  assign ex_cls   = HAS_FP & fw_ie;
  assign done_cls = HAS_FP & mc_fw;

  // EX destination matches a source when index and class agree; int x0 never does.
  function automatic logic ex_hit(input logic [4:0] idx, input logic cls,
                                  input logic [4:0] ex_idx, input logic ex_c);
    return (ex_idx == idx) && (ex_c == cls) && !((ex_c == CLS_INT) && (ex_idx == REG_X0));
  endfunction

  assign lu_hit  = id_valid & ld_ie & wb_ie &
                   (ex_hit(rs1_id, rs1_cls, rd_ie, ex_cls) | ex_hit(rs2_id, rs2_cls, rd_ie, ex_cls));
  assign raw_hit = id_valid & (p_rs1 | p_rs2);
  assign waw_hit = id_valid & wb_id & p_rd;

  // The grant cycle of BUSY frees the unit, so a new op may issue alongside it.
  assign grant_busy = (state == BUSY) & mc_done & ~pipe_wb_valid;
  assign in_drain   = (state == DRAIN);
  assign unit_free  = (state == IDLE) | grant_busy;
  assign struct_hit = id_valid & mc_id & ~unit_free;
  assign req_raw    = id_valid & mc_id & unit_free & ~br_flush & ~lu_hit & ~raw_hit & ~waw_hit;
  assign issue      = req_raw & mc_ack & ~rst;
  assign set_en     = issue & wb_id;
  assign clr_en     = (grant_busy | in_drain) & ~rst;

  sb_regs #(.FLOAT(FLOAT), .NREG(NREG)) u_regs (
    .clk     (clk),
    .rst     (rst),
    .set_en  (set_en),
    .set_cls (rd_cls),
    .set_idx (rd_id),
    .clr_en  (clr_en),
    .clr_cls (done_cls),
    .clr_idx (mc_rd),
    .rs1_cls (rs1_cls),
    .rs1_idx (rs1_id),
    .rs2_cls (rs2_cls),
    .rs2_idx (rs2_id),
    .rd_cls  (rd_cls),
    .rd_idx  (rd_id),
    .p_rs1   (p_rs1),
    .p_rs2   (p_rs2),
    .p_rd    (p_rd)
  );

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and pipeline controls; everything reads as 0 while in reset.
  always_comb begin
    state_nxt = state;
    mc_req    = 1'b0;
    wb_sel    = 1'b0;
    mc_grant  = 1'b0;
    hold_wb   = 1'b0;
    stall_id  = 1'b0;
    bubble_ex = 1'b0;
    case (state)
      IDLE:    if (issue) state_nxt = BUSY;
      BUSY: begin
        if (mc_done) begin
          if (pipe_wb_valid) state_nxt = DRAIN;
          else               state_nxt = issue ? BUSY : IDLE;
        end
      end
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (!rst) begin
      mc_req    = req_raw;
      wb_sel    = grant_busy | in_drain;
      mc_grant  = grant_busy | in_drain;
      hold_wb   = in_drain;
      stall_id  = lu_hit | raw_hit | waw_hit | struct_hit | (req_raw & ~mc_ack) | in_drain;
      bubble_ex = stall_id & ~hold_wb;
    end
  end

  mc_done_in_idle : assert property (@(posedge clk) disable iff (rst) !((state == IDLE) && mc_done));

`ifdef SB_PERF_CNT_EN
  // Stall cycles by cause, one cause per cycle in priority lu > raw/waw > struct.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_lu     <= '0;
      cnt_raw    <= '0;
      cnt_struct <= '0;
    end else if (stall_id) begin
      if (lu_hit)                 cnt_lu     <= sat_inc(cnt_lu);
      else if (raw_hit | waw_hit) cnt_raw    <= sat_inc(cnt_raw);
      else if (struct_hit)        cnt_struct <= sat_inc(cnt_struct);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard. A FLOAT=1 instance is the main
// target; a FLOAT=0 instance shares its inputs and contributes its stall_id
// as the last bit of every expected vector.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, fw_id, wb_id, mc_id, br_flush;
  logic [4:0] rs1_id, rs2_id, rd_id, rd_ie, mc_rd;
  logic [1:0] float_read;
  logic       ld_ie, wb_ie, fw_ie, mc_ack, mc_done, mc_fw, pipe_wb_valid;

  logic mc_req, wb_sel, mc_grant, stall_id, bubble_ex, hold_wb;
  logic i_mc_req, i_wb_sel, i_mc_grant, i_stall_id, i_bubble_ex, i_hold_wb;

`ifdef SB_PERF_CNT_EN
  logic [31:0] cnt_lu, cnt_raw, cnt_struct, i_cnt_lu, i_cnt_raw, i_cnt_struct;
`endif

  int vec_count  = 0;
  int miscompares = 0;
  logic [6:0] exp_q[$];
  string      tag_q[$];

  always #5 clk = ~clk;

  hazard_scoreboard #(.FLOAT(1), .NREG(32)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .float_read(float_read), .rd_id(rd_id), .fw_id(fw_id), .wb_id(wb_id), .mc_id(mc_id),
    .br_flush(br_flush), .ld_ie(ld_ie), .wb_ie(wb_ie), .fw_ie(fw_ie), .rd_ie(rd_ie),
    .mc_req(mc_req), .mc_ack(mc_ack), .mc_done(mc_done), .mc_rd(mc_rd), .mc_fw(mc_fw),
    .pipe_wb_valid(pipe_wb_valid), .wb_sel(wb_sel), .mc_grant(mc_grant),
    .stall_id(stall_id), .bubble_ex(bubble_ex), .hold_wb(hold_wb)
`ifdef SB_PERF_CNT_EN
    , .cnt_lu(cnt_lu), .cnt_raw(cnt_raw), .cnt_struct(cnt_struct)
`endif
  );

  hazard_scoreboard #(.FLOAT(0), .NREG(32)) dut_int (
    .clk(clk), .rst(rst), .id_valid(id_valid), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .float_read(float_read), .rd_id(rd_id), .fw_id(fw_id), .wb_id(wb_id), .mc_id(mc_id),
    .br_flush(br_flush), .ld_ie(ld_ie), .wb_ie(wb_ie), .fw_ie(fw_ie), .rd_ie(rd_ie),
    .mc_req(i_mc_req), .mc_ack(mc_ack), .mc_done(mc_done), .mc_rd(mc_rd), .mc_fw(mc_fw),
    .pipe_wb_valid(pipe_wb_valid), .wb_sel(i_wb_sel), .mc_grant(i_mc_grant),
    .stall_id(i_stall_id), .bubble_ex(i_bubble_ex), .hold_wb(i_hold_wb)
`ifdef SB_PERF_CNT_EN
    , .cnt_lu(i_cnt_lu), .cnt_raw(i_cnt_raw), .cnt_struct(i_cnt_struct)
`endif
  );

  task automatic checkOutput(input string tag, input logic [6:0] got, input logic [6:0] exp);
    vec_count++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %b expected %b (req,sel,grant,stall,bubble,hold,int_stall)",
               tag, got, exp);
    end
  endtask

  // Push the expectation for the inputs just driven, then pop and compare it
  // mid-cycle when the combinational outputs have settled.
  task automatic applyStimulus(input string tag, input logic [6:0] exp);
    logic [6:0] want;
    string      name;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      checkOutput("queue_empty", 7'h7F, 7'h00);
    end else begin
      want = exp_q.pop_front();
      name = tag_q.pop_front();
      checkOutput(name, {mc_req, wb_sel, mc_grant, stall_id, bubble_ex, hold_wb, i_stall_id}, want);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    id_valid = 0; rs1_id = 0; rs2_id = 0; float_read = 0; rd_id = 0; fw_id = 0;
    wb_id = 0; mc_id = 0; br_flush = 0; ld_ie = 0; wb_ie = 0; fw_ie = 0; rd_ie = 0;
    mc_ack = 0; mc_done = 0; mc_rd = 0; mc_fw = 0; pipe_wb_valid = 0;
  endtask

  task automatic setId(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [1:0] fr, input logic [4:0] rd, input logic fw,
                       input logic wb, input logic mc);
    id_valid = v; rs1_id = r1; rs2_id = r2; float_read = fr;
    rd_id = rd; fw_id = fw; wb_id = wb; mc_id = mc;
  endtask

  task automatic setEx(input logic ld, input logic wb, input logic fw, input logic [4:0] rd);
    ld_ie = ld; wb_ie = wb; fw_ie = fw; rd_ie = rd;
  endtask

  initial begin
    clearInputs();
    rst = 1;
    setEx(1, 1, 0, 5);
    setId(1, 5, 1, 2'b00, 0, 0, 0, 0);
    applyStimulus("reset", 7'b0000000);
    rst = 0;

    // load-use
    applyStimulus("lu_rs1", 7'b0001101);
    setEx(0, 1, 0, 5);
    applyStimulus("lu_gone", 7'b0000000);
    setEx(1, 1, 0, 0); setId(1, 0, 1, 2'b00, 0, 0, 0, 0);
    applyStimulus("lu_x0", 7'b0000000);
    setEx(1, 1, 0, 6); setId(1, 1, 6, 2'b00, 0, 0, 0, 0);
    applyStimulus("lu_rs2", 7'b0001101);
    setEx(1, 1, 1, 3); setId(1, 3, 1, 2'b00, 0, 0, 0, 0);
    applyStimulus("fp_load_int_read", 7'b0000001);
    setId(1, 3, 1, 2'b10, 0, 0, 0, 0);
    applyStimulus("fp_load_fp_read", 7'b0001101);

    // div x7, dependent waits through BUSY, clean grant
    setEx(0, 0, 0, 0);
    setId(1, 1, 2, 2'b00, 7, 0, 1, 1); mc_ack = 1;
    applyStimulus("div_issue", 7'b1000000);
    mc_ack = 0; setId(1, 7, 2, 2'b00, 8, 0, 1, 0);
    applyStimulus("raw_busy_a", 7'b0001101);
    applyStimulus("raw_busy_b", 7'b0001101);
    mc_done = 1; mc_rd = 7; mc_fw = 0;
    applyStimulus("grant_bypass", 7'b0110000);
    mc_done = 0;
    applyStimulus("dep_issue", 7'b0000000);

    // write-port conflict and DRAIN
    setId(1, 1, 2, 2'b00, 9, 0, 1, 1); mc_ack = 1;
    applyStimulus("mul_issue", 7'b1000000);
    setId(1, 1, 2, 2'b00, 10, 0, 1, 1); mc_ack = 0;
    applyStimulus("struct_busy", 7'b0001101);
    id_valid = 0; mc_done = 1; mc_rd = 9; pipe_wb_valid = 1;
    applyStimulus("wb_conflict", 7'b0000000);
    applyStimulus("drain", 7'b0111011);
    mc_done = 0; pipe_wb_valid = 0;
    applyStimulus("post_drain", 7'b0000000);

    // delayed ack, then grant with same-cycle issue
    setId(1, 1, 2, 2'b00, 11, 0, 1, 1); mc_ack = 0;
    for (int i = 0; i < 3; i++) applyStimulus("ack_wait", 7'b1001101);
    setId(1, 11, 2, 2'b00, 3, 0, 1, 0);
    applyStimulus("no_pend_pre_ack", 7'b0000000);
    setId(1, 1, 2, 2'b00, 11, 0, 1, 1); mc_ack = 1;
    applyStimulus("ack_issue", 7'b1000000);
    setId(1, 1, 2, 2'b00, 12, 0, 1, 1); mc_ack = 0;
    applyStimulus("struct_second", 7'b0001101);
    mc_done = 1; mc_rd = 11; mc_ack = 1;
    applyStimulus("grant_and_issue", 7'b1110000);
    mc_done = 0; mc_ack = 0; setId(1, 11, 12, 2'b00, 3, 0, 1, 0);
    applyStimulus("raw_new_op", 7'b0001101);
    setId(1, 11, 2, 2'b00, 3, 0, 1, 0);
    applyStimulus("old_rd_clear", 7'b0000000);
    setId(1, 1, 2, 2'b00, 12, 0, 1, 0);
    applyStimulus("waw", 7'b0001101);

    // reset while BUSY with x12 pending
    rst = 1; setId(1, 12, 2, 2'b00, 3, 0, 1, 0);
    applyStimulus("rst_busy", 7'b0000000);
    rst = 0;
    applyStimulus("post_rst_no_stall", 7'b0000000);
    setId(1, 1, 2, 2'b00, 13, 0, 1, 1); mc_ack = 0;
    applyStimulus("idle_after_rst", 7'b1001101);

    // branch flush blocks the issue
    br_flush = 1; mc_ack = 1; setId(1, 1, 2, 2'b00, 14, 0, 1, 1);
    applyStimulus("flush", 7'b0000000);
    br_flush = 0; mc_ack = 0; setId(1, 14, 2, 2'b00, 3, 0, 1, 0);
    applyStimulus("flush_no_pend", 7'b0000000);

    // f0 is a real float register; int x0 never pends
    setId(1, 1, 2, 2'b00, 0, 1, 1, 1); mc_ack = 1;
    applyStimulus("f0_issue", 7'b1000000);
    mc_ack = 0; setId(1, 0, 2, 2'b10, 3, 0, 0, 0);
    applyStimulus("f0_raw", 7'b0001100);
    mc_done = 1; mc_rd = 0; mc_fw = 1;
    applyStimulus("f0_grant", 7'b0110000);
    mc_done = 0; mc_fw = 0;
    applyStimulus("f0_done", 7'b0000000);

    if (exp_q.size() != 0) checkOutput("queue_leftover", 7'(exp_q.size()), 7'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
